stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Three-stage launch vehicle burn sequencer.
// Walks four engine burns (stage 1, stage 2, and two stage-3 burns with a
// re-ignition in between). It presents the engine parameters for the current
// burn, pulses the velocity engine's reset once per burn, and flags stage
// separations, the parking-orbit (LEO) event and mission completion.
module stage_sequencer #(
    parameter int unsigned ISP_1        = 263,
    parameter int unsigned ISP_2        = 421,
    parameter int unsigned ISP_3        = 421,
    parameter int unsigned PROP_1       = 2077000,
    parameter int unsigned PROP_2       = 456100,
    parameter int unsigned PROP_3       = 39136,
    parameter int unsigned PROP_4       = 83864,
    parameter int unsigned BURN_1       = 168,
    parameter int unsigned BURN_2       = 360,
    parameter int unsigned BURN_3       = 165,
    parameter int unsigned BURN_4       = 335,
    parameter int unsigned DRY_1        = 137000,
    parameter int unsigned DRY_2        = 40100,
    parameter int unsigned DRY_3        = 15200,
    parameter int unsigned PAYLOAD      = 27003,
    parameter int unsigned COAST_CYCLES = 4,
    parameter int          N            = 64
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         start,
    input  logic         ignition_end,
    output logic [3:0]   stage_state,
    output logic [N-1:0] specific_impulse,
    output logic [N-1:0] initial_weight,
    output logic [N-1:0] propellant_weight,
    output logic [N-1:0] burntime,
    output logic         engine_resetb,
    output logic         stage_sep,
    output logic         leo_reached,
    output logic         mission_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_BURN  = 3'd3,
        ST_COAST = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Vehicle mass at ignition of each burn: propellant still on board, the
    // structure of every stage not yet dropped, and the payload. Summed at
    // full N-bit width so nothing is truncated.
    localparam logic [N-1:0] IW_4 = N'(PROP_4) + N'(DRY_3) + N'(PAYLOAD);
    localparam logic [N-1:0] IW_3 = IW_4 + N'(PROP_3);
    localparam logic [N-1:0] IW_2 = IW_3 + N'(PROP_2) + N'(DRY_2);
    localparam logic [N-1:0] IW_1 = IW_2 + N'(PROP_1) + N'(DRY_1);

    localparam logic [7:0]   COAST_LOAD = 8'(COAST_CYCLES);
    localparam logic [N-1:0] ZERO_N     = {N{1'b0}};
    localparam logic [N-1:0] ONE_N      = {{(N-1){1'b0}}, 1'b1};

    // Specific impulse per burn; both stage-3 burns share one engine.
    function automatic logic [N-1:0] isp_of(input logic [3:0] stage);
        case (stage)
            4'd1:       isp_of = N'(ISP_1);
            4'd2:       isp_of = N'(ISP_2);
            4'd3, 4'd4: isp_of = N'(ISP_3);
            default:    isp_of = ZERO_N;
        endcase
    endfunction

    // Propellant mass consumed by each burn.
    function automatic logic [N-1:0] prop_of(input logic [3:0] stage);
        case (stage)
            4'd1:    prop_of = N'(PROP_1);
            4'd2:    prop_of = N'(PROP_2);
            4'd3:    prop_of = N'(PROP_3);
            4'd4:    prop_of = N'(PROP_4);
            default: prop_of = ZERO_N;
        endcase
    endfunction

    // Burn duration of each burn.
    function automatic logic [N-1:0] burn_of(input logic [3:0] stage);
        case (stage)
            4'd1:    burn_of = N'(BURN_1);
            4'd2:    burn_of = N'(BURN_2);
            4'd3:    burn_of = N'(BURN_3);
            4'd4:    burn_of = N'(BURN_4);
            default: burn_of = ONE_N;
        endcase
    endfunction

    // Initial vehicle mass of each burn.
    function automatic logic [N-1:0] iw_of(input logic [3:0] stage);
        case (stage)
            4'd1:    iw_of = IW_1;
            4'd2:    iw_of = IW_2;
            4'd3:    iw_of = IW_3;
            4'd4:    iw_of = IW_4;
            default: iw_of = ZERO_N;
        endcase
    endfunction

    state_t       state_r;
    logic [3:0]   stage_r;
    logic [N-1:0] isp_r;
    logic [N-1:0] iw_r;
    logic [N-1:0] pw_r;
    logic [N-1:0] bt_r;
    logic         eng_rstb_r;
    logic         sep_r;
    logic         leo_r;
    logic         done_r;
    logic [7:0]   coast_cnt_r;
    logic         burn_first_r;

    // Burn sequencing FSM; every output is a flop updated here.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r      <= ST_IDLE;
            stage_r      <= 4'd0;
            isp_r        <= ZERO_N;
            iw_r         <= ZERO_N;
            pw_r         <= ZERO_N;
            bt_r         <= ONE_N;
            eng_rstb_r   <= 1'b0;
            sep_r        <= 1'b0;
            leo_r        <= 1'b0;
            done_r       <= 1'b0;
            coast_cnt_r  <= 8'd0;
            burn_first_r <= 1'b0;
        end else begin
            // Event flags are single-cycle pulses unless re-raised below.
            sep_r <= 1'b0;
            leo_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    eng_rstb_r <= 1'b1;
                    if (start) begin
                        stage_r <= 4'd1;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    isp_r      <= isp_of(stage_r);
                    iw_r       <= iw_of(stage_r);
                    pw_r       <= prop_of(stage_r);
                    bt_r       <= burn_of(stage_r);
                    eng_rstb_r <= 1'b0;
                    state_r    <= ST_ARM;
                end
                ST_ARM: begin
                    eng_rstb_r   <= 1'b1;
                    burn_first_r <= 1'b1;
                    state_r      <= ST_BURN;
                end
                ST_BURN: begin
                    // A burn-complete level left over from the previous burn
                    // must not end this one, so the first cycle is blind.
                    if (burn_first_r) begin
                        burn_first_r <= 1'b0;
                    end else if (ignition_end) begin
                        state_r     <= ST_COAST;
                        coast_cnt_r <= COAST_LOAD;
                        // Burn 3 ends in parking orbit; stage 3 is kept for
                        // re-ignition, so there is no separation there.
                        if (stage_r == 4'd3) begin
                            leo_r <= 1'b1;
                        end else begin
                            sep_r <= 1'b1;
                        end
                    end
                end
                ST_COAST: begin
                    // A zero count is treated as expiry so the FSM can never
                    // stall in COAST.
                    if (coast_cnt_r <= 8'd1) begin
                        coast_cnt_r <= 8'd0;
                        if (stage_r < 4'd4) begin
                            stage_r <= stage_r + 4'd1;
                            state_r <= ST_LOAD;
                        end else begin
                            stage_r <= 4'd5;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        coast_cnt_r <= coast_cnt_r - 8'd1;
                    end
                end
                ST_DONE: begin
                    done_r     <= 1'b1;
                    eng_rstb_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign stage_state       = stage_r;
    assign specific_impulse  = isp_r;
    assign initial_weight    = iw_r;
    assign propellant_weight = pw_r;
    assign burntime          = bt_r;
    assign engine_resetb     = eng_rstb_r;
    assign stage_sep         = sep_r;
    assign leo_reached       = leo_r;
    assign mission_done      = done_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer. Stimulus pushes the expected output
// snapshot for every output change, tagged with the sample index at which it
// must appear; the monitor samples on the falling edge and pops one entry
// each time the DUT outputs change. Instance A uses the default 4-cycle
// coast, instance B a 1-cycle coast.
module tb_stage_sequencer;

    localparam int N = 64;

    typedef struct packed {
        logic [3:0]   ss;
        logic [N-1:0] isp;
        logic [N-1:0] iw;
        logic [N-1:0] pw;
        logic [N-1:0] bt;
        logic         eng;
        logic         sep;
        logic         leo;
        logic         done;
    } snap_t;

    typedef struct {
        snap_t s;
        int    at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb_a = 1'b1, start_a = 1'b0, ign_a = 1'b0;
    logic resetb_b = 1'b1, start_b = 1'b0, ign_b = 1'b0;

    logic [3:0]   ss_a, ss_b;
    logic [N-1:0] isp_a, iw_a, pw_a, bt_a, isp_b, iw_b, pw_b, bt_b;
    logic         eng_a, sep_a, leo_a, done_a, eng_b, sep_b, leo_b, done_b;

    stage_sequencer dut_a (
        .clk(clk), .resetb(resetb_a), .start(start_a), .ignition_end(ign_a),
        .stage_state(ss_a), .specific_impulse(isp_a), .initial_weight(iw_a),
        .propellant_weight(pw_a), .burntime(bt_a), .engine_resetb(eng_a),
        .stage_sep(sep_a), .leo_reached(leo_a), .mission_done(done_a)
    );

    stage_sequencer #(.COAST_CYCLES(1)) dut_b (
        .clk(clk), .resetb(resetb_b), .start(start_b), .ignition_end(ign_b),
        .stage_state(ss_b), .specific_impulse(isp_b), .initial_weight(iw_b),
        .propellant_weight(pw_b), .burntime(bt_b), .engine_resetb(eng_b),
        .stage_sep(sep_b), .leo_reached(leo_b), .mission_done(done_b)
    );

    exp_t  qa[$];
    exp_t  qb[$];
    int    sample_idx = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    snap_t last_a, last_b;
    bit    first_a = 1'b1, first_b = 1'b1;

    // Expected snapshot. k selects the parameter set: 0 = reset values,
    // 1..4 = burn k. Initial weights are hand sums of propellant left,
    // structure left and payload:
    //   burn 1: 2656100 + 192300 + 27003 = 2875403
    //   burn 2:  579100 +  55300 + 27003 =  661403
    //   burn 3:  123000 +  15200 + 27003 =  165203
    //   burn 4:   83864 +  15200 + 27003 =  126067
    function automatic snap_t mk(input int ss, input int k, input bit eng,
                                 input bit sep, input bit leo, input bit done);
        snap_t r;
        r.ss = 4'(ss);
        case (k)
            1: begin r.isp = 64'd263; r.iw = 64'd2875403; r.pw = 64'd2077000; r.bt = 64'd168; end
            2: begin r.isp = 64'd421; r.iw = 64'd661403;  r.pw = 64'd456100;  r.bt = 64'd360; end
            3: begin r.isp = 64'd421; r.iw = 64'd165203;  r.pw = 64'd39136;   r.bt = 64'd165; end
            4: begin r.isp = 64'd421; r.iw = 64'd126067;  r.pw = 64'd83864;   r.bt = 64'd335; end
            default: begin r.isp = 64'd0; r.iw = 64'd0; r.pw = 64'd0; r.bt = 64'd1; end
        endcase
        r.eng  = eng;
        r.sep  = sep;
        r.leo  = leo;
        r.done = done;
        return r;
    endfunction

    task automatic push(input int inst, input int at, input snap_t s);
        exp_t e;
        e.s  = s;
        e.at = at;
        if (inst == 0) qa.push_back(e);
        else           qb.push_back(e);
    endtask

    task automatic set_ign(input int inst, input bit v);
        if (inst == 0) ign_a = v; else ign_b = v;
    endtask

    task automatic set_start(input int inst, input bit v);
        if (inst == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_rstb(input int inst, input bit v);
        if (inst == 0) resetb_a = v; else resetb_b = v;
    endtask

    task automatic judge(input string nm, input snap_t act, input exp_t e, input bit have);
        n_vec++;
        if (!have) begin
            n_bad++;
            $display("FAIL %s unexpected_change sample %0d: got ss=%0d iw=%0d eng=%b sep=%b leo=%b done=%b, required no change",
                     nm, sample_idx, act.ss, act.iw, act.eng, act.sep, act.leo, act.done);
        end else if (act !== e.s || (e.at >= 0 && e.at != sample_idx)) begin
            n_bad++;
            $display("FAIL %s snapshot sample %0d (required at %0d): got ss=%0d isp=%0d iw=%0d pw=%0d bt=%0d eng=%b sep=%b leo=%b done=%b, required ss=%0d isp=%0d iw=%0d pw=%0d bt=%0d eng=%b sep=%b leo=%b done=%b",
                     nm, sample_idx, e.at, act.ss, act.isp, act.iw, act.pw, act.bt, act.eng, act.sep, act.leo, act.done,
                     e.s.ss, e.s.isp, e.s.iw, e.s.pw, e.s.bt, e.s.eng, e.s.sep, e.s.leo, e.s.done);
        end
    endtask

    // Monitor: count samples, pop and compare on every output change.
    always @(negedge clk) begin
        snap_t ca, cb;
        exp_t  ea, eb;
        bit    ha, hb;
        sample_idx = sample_idx + 1;
        ca = '{ss_a, isp_a, iw_a, pw_a, bt_a, eng_a, sep_a, leo_a, done_a};
        cb = '{ss_b, isp_b, iw_b, pw_b, bt_b, eng_b, sep_b, leo_b, done_b};
        if (first_a || ca !== last_a) begin
            ha = (qa.size() != 0);
            if (ha) ea = qa.pop_front();
            judge("A", ca, ea, ha);
            last_a  = ca;
            first_a = 1'b0;
        end
        if (first_b || cb !== last_b) begin
            hb = (qb.size() != 0);
            if (hb) eb = qb.pop_front();
            judge("B", cb, eb, hb);
            last_b  = cb;
            first_b = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs set now (after edge E_j, sample_idx = j-1) are first seen by
    // edge E_{j+1}, whose effect appears at sample sample_idx + 2.
    task automatic wait_until(input int idx);
        int guard = 0;
        while (sample_idx < idx && guard < 2000) begin
            tick();
            guard++;
        end
    endtask

    // One mission from IDLE. c1..c4: BURN cycle in which ignition_end is
    // seen. stale: ignition_end high from start through the first BURN cycle
    // of burn 1. extra: during burn 2 pulse start in BURN and ignition_end in
    // COAST. abort_burn: assert reset one cycle into that burn's COAST.
    task automatic mission(input int inst, input int coast, input int c1, input int c2,
                           input int c3, input int c4, input bit stale, input bit extra,
                           input int abort_burn);
        int l, x, c, last_t, s;
        bit aborted;
        s = sample_idx;
        set_start(inst, 1'b1);
        set_ign(inst, stale);
        push(inst, s + 2, mk(1, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        l = s + 2;
        aborted = 1'b0;
        for (int k = 1; k <= 4 && !aborted; k++) begin
            c = (k == 1) ? c1 : (k == 2) ? c2 : (k == 3) ? c3 : c4;
            x = l + 2 + c;
            push(inst, l + 1, mk(k, k, 1'b0, 1'b0, 1'b0, 1'b0));
            push(inst, l + 2, mk(k, k, 1'b1, 1'b0, 1'b0, 1'b0));
            push(inst, x, mk(k, k, 1'b1, k != 3, k == 3, 1'b0));
            if (abort_burn == k) begin
                push(inst, x + 1, mk(k, k, 1'b1, 1'b0, 1'b0, 1'b0));
                push(inst, x + 2, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
                last_t = x + 1;
            end else begin
                if (coast > 1) push(inst, x + 1, mk(k, k, 1'b1, 1'b0, 1'b0, 1'b0));
                if (k < 4) push(inst, x + coast, mk(k + 1, k, 1'b1, 1'b0, 1'b0, 1'b0));
                else       push(inst, x + coast, mk(5, 4, 1'b1, 1'b0, 1'b0, 1'b1));
                last_t = x + coast - 1;
            end
            for (int t = sample_idx; t <= last_t; t++) begin
                wait_until(t);
                set_ign(inst, (stale && k == 1 && t < l + 2) || (t == l + c) ||
                              (extra && k == 2 && coast > 2 && t == x + 1));
                set_start(inst, extra && k == 2 && t == l + 2);
                if (abort_burn == k && t == x + 1) set_rstb(inst, 1'b0);
            end
            aborted = (abort_burn == k);
            l = x + coast;
        end
        set_ign(inst, 1'b0);
        set_start(inst, 1'b0);
    endtask

    // Stimulus sequence.
    initial begin
        int u;
        #2;
        resetb_a = 1'b0;
        resetb_b = 1'b0;
        push(0, -1, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        push(1, -1, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        wait_until(3);
        resetb_a = 1'b1;
        push(0, 5, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_until(7);

        // Full mission: stale ignition level on burn 1, ignored inputs on burn 2.
        mission(0, 4, 3, 2, 4, 2, 1'b1, 1'b1, 0);

        // start and ignition_end in DONE change nothing.
        wait_until(sample_idx + 2);
        start_a = 1'b1;
        ign_a   = 1'b1;
        tick();
        start_a = 1'b0;
        ign_a   = 1'b0;
        repeat (5) tick();

        // Reset out of DONE.
        u = sample_idx;
        resetb_a = 1'b0;
        push(0, u + 1, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_until(u + 2);
        resetb_a = 1'b1;
        push(0, u + 4, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_until(u + 6);

        // Reset mid-COAST of burn 2, then a fresh mission reloads stage 1.
        mission(0, 4, 2, 2, 2, 2, 1'b0, 1'b0, 2);
        u = sample_idx;
        wait_until(u + 2);
        resetb_a = 1'b1;
        push(0, u + 4, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_until(u + 6);
        mission(0, 4, 2, 3, 2, 2, 1'b0, 1'b0, 0);

        // One-cycle coast variant.
        u = sample_idx;
        resetb_b = 1'b1;
        push(1, u + 2, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_until(u + 4);
        mission(1, 1, 2, 2, 2, 2, 1'b0, 1'b0, 0);

        repeat (6) tick();
        n_vec++;
        if (qa.size() != 0) begin
            n_bad++;
            $display("FAIL A drain: %0d expected changes never seen, required 0", qa.size());
        end
        n_vec++;
        if (qb.size() != 0) begin
            n_bad++;
            $display("FAIL B drain: %0d expected changes never seen, required 0", qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
